// File: rtl/parking_counter.sv
`default_nettype none
// ============================================================================
//  Module      : parking_counter
//  Description : Multi-lane car park occupancy counter. Each lane has an
//                outer (sensor1) and inner (sensor2) light beam; a per-lane
//                direction FSM recognises complete entries and exits and
//                emits one-cycle incr/decr pulses. A saturating occupancy
//                counter sums the pulses of all lanes every cycle and flags
//                overflow/underflow attempts.
//                Optional build macro PARKING_DEBOUNCE_EN inserts a 2-flop
//                synchroniser and a DEBOUNCE_CYCLES-sample filter on every
//                sensor bit; without it raw sensors drive the FSMs directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_counter #(
   parameter int N_LANES         = 2,
   parameter int CAPACITY        = 100,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W          = $clog2(CAPACITY + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LANES-1:0] sensor1,
   input  logic [N_LANES-1:0] sensor2,
   output logic [N_LANES-1:0] incr,
   output logic [N_LANES-1:0] decr,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty,
   output logic               ovf,
   output logic               unf
);

   // Signed arithmetic width for count + delta: four spare bits cover the
   // sign and a delta of up to +/-8 lanes on top of CAPACITY.
   localparam int DW = CNT_W + 4;
   localparam logic signed [DW-1:0] CAP_S = DW'(CAPACITY);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ------------------------------------------------------------------------
   if (N_LANES < 1 || N_LANES > 8) begin : g_chk_lanes
      $error("parking_counter: N_LANES must be in 1..8");
   end
   if (CAPACITY < 1 || CAPACITY > 65535) begin : g_chk_capacity
      $error("parking_counter: CAPACITY must be in 1..65535");
   end
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_chk_debounce
      $error("parking_counter: DEBOUNCE_CYCLES must be in 2..255");
   end

   // ------------------------------------------------------------------------
   // Sensor conditioning. Bit l is sensor1 of lane l, bit N_LANES+l is
   // sensor2 of lane l.
   // ------------------------------------------------------------------------
   logic [2*N_LANES-1:0] raw_sens;
   logic [2*N_LANES-1:0] filt_sens;

   assign raw_sens = {sensor2, sensor1};

`ifdef PARKING_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

   for (genvar b = 0; b < 2*N_LANES; b++) begin : g_debounce
      logic            sync1_q;
      logic            sync2_q;
      logic            filt_q;
      logic [DB_W-1:0] run_q;

      // Synchronise the beam, then accept a new level only after it has been
      // seen DEBOUNCE_CYCLES times in a row; any return to the current
      // filtered level restarts the run.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            run_q   <= '0;
         end else begin
            sync1_q <= raw_sens[b];
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
               run_q <= '0;
            end else if (run_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               filt_q <= sync2_q;
               run_q  <= '0;
            end else begin
               run_q <= run_q + 1'b1;
            end
         end
      end

      assign filt_sens[b] = filt_q;
   end
`else
   assign filt_sens = raw_sens;
`endif

   // ------------------------------------------------------------------------
   // Per-lane direction FSMs
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_IN_1  = 3'd1,
      ST_IN_2  = 3'd2,
      ST_IN_3  = 3'd3,
      ST_OUT_1 = 3'd4,
      ST_OUT_2 = 3'd5,
      ST_OUT_3 = 3'd6
   } lane_state_e;

   logic [N_LANES-1:0] incr_raw;
   logic [N_LANES-1:0] decr_raw;

   for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      lane_state_e state_q;
      lane_state_e state_d;
      logic [1:0]  sens;      // {s1, s2}
      logic        lane_inc;
      logic        lane_dec;

      assign sens = {filt_sens[l], filt_sens[N_LANES + l]};

      // Lane state register; reset discards any vehicle in transit.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
         end else begin
            state_q <= state_d;
         end
      end

      // Next-state and Mealy completion pulses. Entry runs 10,11,01,00;
      // exit is the mirror 01,11,10,00. Reversals step back, 00 before the
      // last stage aborts silently.
      always_comb begin
         state_d  = state_q;
         lane_inc = 1'b0;
         lane_dec = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sens == 2'b10)      state_d = ST_IN_1;
               else if (sens == 2'b01) state_d = ST_OUT_1;
            end
            ST_IN_1: begin
               if (sens == 2'b11)      state_d = ST_IN_2;
               else if (sens == 2'b00) state_d = ST_IDLE;
            end
            ST_IN_2: begin
               case (sens)
                  2'b01:   state_d = ST_IN_3;
                  2'b10:   state_d = ST_IN_1;
                  2'b00:   state_d = ST_IDLE;
                  default: state_d = ST_IN_2;
               endcase
            end
            ST_IN_3: begin
               case (sens)
                  2'b00: begin
                     state_d  = ST_IDLE;
                     lane_inc = 1'b1;
                  end
                  2'b11:   state_d = ST_IN_2;
                  2'b10:   state_d = ST_IN_1;
                  default: state_d = ST_IN_3;
               endcase
            end
            ST_OUT_1: begin
               if (sens == 2'b11)      state_d = ST_OUT_2;
               else if (sens == 2'b00) state_d = ST_IDLE;
            end
            ST_OUT_2: begin
               case (sens)
                  2'b10:   state_d = ST_OUT_3;
                  2'b01:   state_d = ST_OUT_1;
                  2'b00:   state_d = ST_IDLE;
                  default: state_d = ST_OUT_2;
               endcase
            end
            ST_OUT_3: begin
               case (sens)
                  2'b00: begin
                     state_d  = ST_IDLE;
                     lane_dec = 1'b1;
                  end
                  2'b11:   state_d = ST_OUT_2;
                  2'b01:   state_d = ST_OUT_1;
                  default: state_d = ST_OUT_3;
               endcase
            end
            default: state_d = ST_IDLE;
         endcase
      end

      assign incr_raw[l] = lane_inc;
      assign decr_raw[l] = lane_dec;
   end

   // ------------------------------------------------------------------------
   // Occupancy counter
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;
   logic [DW-1:0]        n_inc;
   logic [DW-1:0]        n_dec;
   logic signed [DW-1:0] delta;
   logic signed [DW-1:0] sum;
   logic                 ovf_c;
   logic                 unf_c;

   // Net change of this cycle and the saturated next occupancy. Opposing
   // pulses cancel before saturation, so they never flag ovf/unf.
   always_comb begin
      n_inc = '0;
      n_dec = '0;
      for (int i = 0; i < N_LANES; i++) begin
         n_inc = n_inc + {{(DW-1){1'b0}}, incr_raw[i]};
         n_dec = n_dec + {{(DW-1){1'b0}}, decr_raw[i]};
      end
      delta = $signed(n_inc) - $signed(n_dec);
      sum   = $signed({4'b0000, count_q}) + delta;
      unf_c = sum[DW-1];
      ovf_c = !sum[DW-1] && (sum > CAP_S);
      if (ovf_c) begin
         count_d = CNT_W'(CAPACITY);
      end else if (unf_c) begin
         count_d = '0;
      end else begin
         count_d = sum[CNT_W-1:0];
      end
   end

   // Occupancy register, updated at the edge that closes the pulse cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flags come from the registered count so they align with count itself.
   assign count = count_q;
   assign full  = (count_q == CNT_W'(CAPACITY));
   assign empty = (count_q == '0);

   // Pulses are forced low while reset is held.
   assign incr = incr_raw & {N_LANES{~rst}};
   assign decr = decr_raw & {N_LANES{~rst}};
   assign ovf  = ovf_c & ~rst;
   assign unf  = unf_c & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_parking_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_counter
//  Description : Self-checking bench for parking_counter. Two instances share
//                the sensors: one with CAPACITY 8, one with CAPACITY 2 for the
//                saturation cases. A vehicle-position reference model predicts
//                pulses, occupancy and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_counter;

   localparam int NL    = 2;
   localparam int CAP_A = 8;
   localparam int CAP_B = 2;
   localparam int DB    = 4;
   localparam int CW_A  = $clog2(CAP_A + 1);
   localparam int CW_B  = $clog2(CAP_B + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NL-1:0]   sensor1 = '0;
   logic [NL-1:0]   sensor2 = '0;
   logic [NL-1:0]   incr_a, decr_a, incr_b, decr_b;
   logic [CW_A-1:0] count_a;
   logic [CW_B-1:0] count_b;
   logic            full_a, empty_a, ovf_a, unf_a;
   logic            full_b, empty_b, ovf_b, unf_b;

   parking_counter #(.N_LANES(NL), .CAPACITY(CAP_A), .DEBOUNCE_CYCLES(DB)) u_dut (
      .clk(clk), .rst(rst), .sensor1(sensor1), .sensor2(sensor2),
      .incr(incr_a), .decr(decr_a), .count(count_a), .full(full_a),
      .empty(empty_a), .ovf(ovf_a), .unf(unf_a)
   );

   parking_counter #(.N_LANES(NL), .CAPACITY(CAP_B), .DEBOUNCE_CYCLES(DB)) u_cap (
      .clk(clk), .rst(rst), .sensor1(sensor1), .sensor2(sensor2),
      .incr(incr_b), .decr(decr_b), .count(count_b), .full(full_b),
      .empty(empty_b), .ovf(ovf_b), .unf(unf_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: per lane, how far a vehicle has travelled through the
   // beam pair (0 = none, 1..3 = stages) and which way it is going.
   int  m_pos [NL];
   bit  m_out [NL];
   int  m_occ_a = 0;
   int  m_occ_b = 0;

   // Expectations for the current cycle (before its closing edge).
   logic [NL-1:0] e_incr, e_decr;
   logic          e_ovf_a, e_unf_a, e_ovf_b, e_unf_b;
   int            e_cnt_a, e_cnt_b;

   // Observed pulse tallies for the directed scenarios.
   int t_inc [NL];
   int t_dec [NL];
   int t_ovf_a, t_unf_a, t_ovf_b, t_unf_b;

   // Stage reached by a vehicle for a given beam pattern {s1,s2}.
   function automatic int pos_of(bit out_dir, logic [1:0] pat);
      if (pat == 2'b11) return 2;
      if (pat == 2'b10) return out_dir ? 3 : 1;
      if (pat == 2'b01) return out_dir ? 1 : 3;
      return 0;
   endfunction

   function automatic int clamp(int v, int cap);
      if (v > cap) return cap;
      if (v < 0) return 0;
      return v;
   endfunction

   task automatic clear_tallies();
      for (int l = 0; l < NL; l++) begin
         t_inc[l] = 0;
         t_dec[l] = 0;
      end
      t_ovf_a = 0; t_unf_a = 0; t_ovf_b = 0; t_unf_b = 0;
   endtask

   // One clock cycle: drive patterns p0 (lane 0) and p1 (lane 1) as {s1,s2},
   // compute the model's expectations and advance the model past the edge.
   task automatic step(input logic [1:0] p0, input logic [1:0] p1, input logic r);
      logic [1:0] pat;
      int np, net, sa, sb, p;
      bit nd;
      @(negedge clk);
      sensor1 = {p1[1], p0[1]};
      sensor2 = {p1[0], p0[0]};
      rst     = r;
      #1;
      e_incr = '0;
      e_decr = '0;
      net    = 0;
      for (int l = 0; l < NL; l++) begin
         pat = (l == 0) ? p0 : p1;
         np  = m_pos[l];
         nd  = m_out[l];
         if (pat == 2'b00) begin
            if (m_pos[l] == 3 && !r) begin
               if (m_out[l]) begin e_decr[l] = 1'b1; net--; end
               else          begin e_incr[l] = 1'b1; net++; end
            end
            np = 0;
         end else if (m_pos[l] == 0) begin
            if (pat == 2'b10)      begin np = 1; nd = 1'b0; end
            else if (pat == 2'b01) begin np = 1; nd = 1'b1; end
         end else begin
            p = pos_of(m_out[l], pat);
            if (!(m_pos[l] == 1 && p == 3)) np = p;
         end
         m_pos[l] = r ? 0 : np;
         m_out[l] = nd;
      end
      e_cnt_a = m_occ_a;
      e_cnt_b = m_occ_b;
      sa = m_occ_a + net;
      sb = m_occ_b + net;
      e_ovf_a = !r && (sa > CAP_A);
      e_unf_a = !r && (sa < 0);
      e_ovf_b = !r && (sb > CAP_B);
      e_unf_b = !r && (sb < 0);
      m_occ_a = r ? 0 : clamp(sa, CAP_A);
      m_occ_b = r ? 0 : clamp(sb, CAP_B);
      for (int l = 0; l < NL; l++) begin
         t_inc[l] += int'(incr_a[l]);
         t_dec[l] += int'(decr_a[l]);
      end
      t_ovf_a += int'(ovf_a);
      t_unf_a += int'(unf_a);
      t_ovf_b += int'(ovf_b);
      t_unf_b += int'(unf_b);
   endtask

   task automatic hold(input logic [1:0] p0, input logic [1:0] p1, input int n);
      repeat (n) step(p0, p1, 1'b0);
   endtask

   task automatic entry_lane0();
      hold(2'b00, 2'b00, 8); hold(2'b10, 2'b00, 8); hold(2'b11, 2'b00, 8);
      hold(2'b01, 2'b00, 8); hold(2'b00, 2'b00, 8);
   endtask

   task automatic test_reset();
      repeat (3) step(2'b00, 2'b00, 1'b1);
      total++; if (count_a !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count_a); end
      total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", empty_a); end
      total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", full_a); end
      total++; if ({incr_a, decr_a, ovf_a, unf_a} !== '0) begin bad++;
         $display("FAIL reset_pulses: got %b expected 0", {incr_a, decr_a, ovf_a, unf_a}); end
      // Blocked beams at reset release must not be taken as a vehicle.
      clear_tallies();
      repeat (4) step(2'b11, 2'b11, 1'b1);
      hold(2'b11, 2'b11, 6); hold(2'b01, 2'b10, 6); hold(2'b00, 2'b00, 6);
      total++; if (t_inc[0] + t_inc[1] + t_dec[0] + t_dec[1] !== 0) begin bad++;
         $display("FAIL reset_release_pulses: got %0d expected 0", t_inc[0] + t_inc[1] + t_dec[0] + t_dec[1]); end
   endtask

   task automatic test_entry();
      clear_tallies();
      entry_lane0();
      total++; if (t_inc[0] !== 1) begin bad++; $display("FAIL entry_incr0: got %0d expected 1", t_inc[0]); end
      total++; if (t_dec[0] + t_dec[1] + t_inc[1] !== 0) begin bad++;
         $display("FAIL entry_other_pulses: got %0d expected 0", t_dec[0] + t_dec[1] + t_inc[1]); end
      total++; if (count_a !== 4'd1) begin bad++; $display("FAIL entry_count: got %0d expected 1", count_a); end
      total++; if (empty_a !== 1'b0) begin bad++; $display("FAIL entry_empty: got %b expected 0", empty_a); end
   endtask

   task automatic test_exit();
      entry_lane0();
      entry_lane0();
      total++; if (count_a !== 4'd3) begin bad++; $display("FAIL exit_precount: got %0d expected 3", count_a); end
      clear_tallies();
      hold(2'b00, 2'b00, 8); hold(2'b00, 2'b01, 8); hold(2'b00, 2'b11, 8);
      hold(2'b00, 2'b10, 8); hold(2'b00, 2'b00, 8);
      total++; if (t_dec[1] !== 1) begin bad++; $display("FAIL exit_decr1: got %0d expected 1", t_dec[1]); end
      total++; if (t_inc[0] + t_inc[1] !== 0) begin bad++; $display("FAIL exit_incr: got %0d expected 0", t_inc[0] + t_inc[1]); end
      total++; if (count_a !== 4'd2) begin bad++; $display("FAIL exit_count: got %0d expected 2", count_a); end
   endtask

   task automatic test_abort();
      clear_tallies();
      hold(2'b10, 2'b00, 8); hold(2'b11, 2'b00, 8); hold(2'b10, 2'b00, 8); hold(2'b00, 2'b00, 8);
      total++; if (t_inc[0] + t_dec[0] !== 0) begin bad++; $display("FAIL abort_pulses: got %0d expected 0", t_inc[0] + t_dec[0]); end
      total++; if (count_a !== 4'd2) begin bad++; $display("FAIL abort_count: got %0d expected 2", count_a); end
   endtask

   task automatic test_overflow();
      // Small instance sits at 1 here; one entry fills it.
      entry_lane0();
      total++; if (count_b !== 2'd2) begin bad++; $display("FAIL ovf_fill_count: got %0d expected 2", count_b); end
      total++; if (full_b !== 1'b1) begin bad++; $display("FAIL ovf_fill_full: got %b expected 1", full_b); end
      clear_tallies();
      entry_lane0();
      total++; if (t_inc[0] !== 1) begin bad++; $display("FAIL ovf_incr0: got %0d expected 1", t_inc[0]); end
      total++; if (t_ovf_b !== 1) begin bad++; $display("FAIL ovf_pulse: got %0d expected 1", t_ovf_b); end
      total++; if (count_b !== 2'd2) begin bad++; $display("FAIL ovf_count: got %0d expected 2", count_b); end
      total++; if (full_b !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b expected 1", full_b); end
      total++; if (t_ovf_a !== 0) begin bad++; $display("FAIL ovf_large_inst: got %0d expected 0", t_ovf_a); end
      // Entry on lane 0 and exit on lane 1 completing together while full.
      clear_tallies();
      hold(2'b10, 2'b01, 8); hold(2'b11, 2'b11, 8); hold(2'b01, 2'b10, 8); hold(2'b00, 2'b00, 8);
      total++; if (t_inc[0] !== 1 || t_dec[1] !== 1) begin bad++;
         $display("FAIL cancel_pulses: got incr0=%0d decr1=%0d expected 1 1", t_inc[0], t_dec[1]); end
      total++; if (t_ovf_b + t_unf_b !== 0) begin bad++; $display("FAIL cancel_flags: got %0d expected 0", t_ovf_b + t_unf_b); end
      total++; if (count_b !== 2'd2) begin bad++; $display("FAIL cancel_count_small: got %0d expected 2", count_b); end
      total++; if (count_a !== 4'd4) begin bad++; $display("FAIL cancel_count_large: got %0d expected 4", count_a); end
   endtask

   task automatic test_reset_mid();
      entry_lane0();
      total++; if (count_a !== 4'd5) begin bad++; $display("FAIL rmid_precount: got %0d expected 5", count_a); end
      hold(2'b10, 2'b00, 4); hold(2'b11, 2'b00, 4);
      clear_tallies();
      step(2'b11, 2'b00, 1'b1);
      step(2'b11, 2'b00, 1'b0);
      total++; if (count_a !== '0) begin bad++; $display("FAIL rmid_count: got %0d expected 0", count_a); end
      total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %b expected 1", empty_a); end
      hold(2'b01, 2'b00, 8); hold(2'b00, 2'b00, 8);
      total++; if (t_inc[0] + t_dec[0] !== 0) begin bad++; $display("FAIL rmid_pulses: got %0d expected 0", t_inc[0] + t_dec[0]); end
      total++; if (count_a !== '0) begin bad++; $display("FAIL rmid_final_count: got %0d expected 0", count_a); end
   endtask

   // Random traffic; patterns mostly follow a travel direction so that
   // entries, exits, reversals and aborts all occur.
   task automatic test_random();
      logic [1:0] pat [NL];
      int         left [NL];
      bit         rdir [NL];
      logic [1:0] seq_in [4];
      logic [CW_A-1:0] ea;
      logic [CW_B-1:0] eb;
      logic r;
      int idx [NL];
      seq_in = '{2'b00, 2'b10, 2'b11, 2'b01};
      step(2'b00, 2'b00, 1'b1);
      for (int l = 0; l < NL; l++) begin
         pat[l] = 2'b00; left[l] = 1; rdir[l] = 1'b0; idx[l] = 0;
      end
      for (int c = 0; c < 1500; c++) begin
         for (int l = 0; l < NL; l++) begin
            left[l]--;
            if (left[l] <= 0) begin
               left[l] = $urandom_range(1, 3);
               if ($urandom_range(0, 9) < 7) begin
                  if (idx[l] == 0) rdir[l] = $urandom_range(0, 1) == 1;
                  idx[l] = (idx[l] + 1) % 4;
               end else begin
                  idx[l] = $urandom_range(0, 3);
               end
               pat[l] = seq_in[idx[l]];
               if (rdir[l]) pat[l] = {pat[l][0], pat[l][1]};
            end
         end
         r = ($urandom_range(0, 299) == 0);
         step(pat[0], pat[1], r);
         ea = CW_A'(e_cnt_a);
         eb = CW_B'(e_cnt_b);
         total++; if (incr_a !== e_incr) begin bad++; $display("FAIL rnd_incr c=%0d: got %b expected %b", c, incr_a, e_incr); end
         total++; if (decr_a !== e_decr) begin bad++; $display("FAIL rnd_decr c=%0d: got %b expected %b", c, decr_a, e_decr); end
         total++; if ({incr_b, decr_b} !== {e_incr, e_decr}) begin bad++;
            $display("FAIL rnd_pulses_small c=%0d: got %b expected %b", c, {incr_b, decr_b}, {e_incr, e_decr}); end
         total++; if ({ovf_a, unf_a} !== {e_ovf_a, e_unf_a}) begin bad++;
            $display("FAIL rnd_flags_large c=%0d: got %b expected %b", c, {ovf_a, unf_a}, {e_ovf_a, e_unf_a}); end
         total++; if ({ovf_b, unf_b} !== {e_ovf_b, e_unf_b}) begin bad++;
            $display("FAIL rnd_flags_small c=%0d: got %b expected %b", c, {ovf_b, unf_b}, {e_ovf_b, e_unf_b}); end
         total++; if (count_a !== ea) begin bad++; $display("FAIL rnd_count_large c=%0d: got %0d expected %0d", c, count_a, ea); end
         total++; if (count_b !== eb) begin bad++; $display("FAIL rnd_count_small c=%0d: got %0d expected %0d", c, count_b, eb); end
         total++; if ({full_a, empty_a, full_b, empty_b} !== {e_cnt_a == CAP_A, e_cnt_a == 0, e_cnt_b == CAP_B, e_cnt_b == 0}) begin bad++;
            $display("FAIL rnd_full_empty c=%0d: got %b expected %b", c, {full_a, empty_a, full_b, empty_b},
                     {e_cnt_a == CAP_A, e_cnt_a == 0, e_cnt_b == CAP_B, e_cnt_b == 0}); end
      end
   endtask

   task automatic test_debounce();
      int found;
      hold(2'b00, 2'b00, 10); hold(2'b10, 2'b00, 10); hold(2'b11, 2'b00, 10); hold(2'b01, 2'b00, 10);
      // A 2-cycle drop to 00 from stage 3 would complete an entry if seen.
      clear_tallies();
      hold(2'b00, 2'b00, 2); hold(2'b01, 2'b00, 12);
      total++; if (t_inc[0] + t_dec[0] !== 0) begin bad++; $display("FAIL db_glitch: got %0d expected 0", t_inc[0] + t_dec[0]); end
      total++; if (count_a !== '0) begin bad++; $display("FAIL db_glitch_count: got %0d expected 0", count_a); end
      found = -1;
      for (int k = 0; k < 40; k++) begin
         step(2'b00, 2'b00, 1'b0);
         if (incr_a[0] === 1'b1 && found < 0) found = k;
      end
      total++; if (found !== 2 + DB) begin bad++; $display("FAIL db_latency: got %0d expected %0d", found, 2 + DB); end
      total++; if (count_a !== 4'd1) begin bad++; $display("FAIL db_count: got %0d expected 1", count_a); end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) begin
         m_pos[l] = 0;
         m_out[l] = 1'b0;
      end
      clear_tallies();
      test_reset();
`ifdef PARKING_DEBOUNCE_EN
      test_debounce();
`else
      test_entry();
      test_exit();
      test_abort();
      test_overflow();
      test_reset_mid();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/parking_counter.md
PARKING_COUNTER -- requirements
Module: parking_counter

Interface
REQ-001 Parameter: N_LANES, default 2, number of independent entry/exit lanes (1..8).
REQ-002 Parameter: CAPACITY, default 100, maximum occupancy (1..65535).
REQ-003 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable samples required by the debounce filter (2..255).
REQ-004 Derived localparam: CNT_W = $clog2(CAPACITY+1).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock, all state updates on posedge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 sensor1  input  N_LANES  outer beam per lane, 1 = blocked.
REQ-009 sensor2  input  N_LANES  inner beam per lane, 1 = blocked.
REQ-010 incr  output  N_LANES  one-cycle pulse per completed entry, per lane.
REQ-011 decr  output  N_LANES  one-cycle pulse per completed exit, per lane.
REQ-012 count  output  CNT_W  registered current occupancy.
REQ-013 full  output  1  registered, high when count == CAPACITY.
REQ-014 empty  output  1  registered, high when count == 0.
REQ-015 ovf  output  1  one-cycle pulse when an update would exceed CAPACITY.
REQ-016 unf  output  1  one-cycle pulse when an update would go below 0.

Function
REQ-017 Each lane SHALL run an independent registered FSM: IDLE, IN_1, IN_2, IN_3, OUT_1, OUT_2, OUT_3; {s1,s2} denotes that lane's filtered sensors.
REQ-018 IDLE: 10 -> IN_1; 01 -> OUT_1; 00 and 11 -> stay IDLE.
REQ-019 IN_1: 11 -> IN_2; 00 -> IDLE (abort); else stay. OUT_1: 11 -> OUT_2; 00 -> IDLE; else stay.
REQ-020 IN_2: 01 -> IN_3; 10 -> IN_1 (reversal); 00 -> IDLE; 11 stay. OUT_2 mirrored: 10 -> OUT_3; 01 -> OUT_1; 00 -> IDLE.
REQ-021 IN_3: 00 -> IDLE with incr pulse; 11 -> IN_2 (reversal); 10 -> IN_1; 01 stay. OUT_3 mirrored with decr pulse; 11 -> OUT_2; 01 -> OUT_1.
REQ-022 incr/decr SHALL be combinational Mealy outputs asserted in the cycle the completing transition is taken; never both high on one lane.
REQ-023 Per cycle the net delta SHALL be popcount(incr) - popcount(decr), computed at CNT_W+4 bits signed.
REQ-024 count SHALL update at the same clock edge that ends the pulse cycle (count visible one cycle after the pulse).
REQ-025 If count + delta > CAPACITY, count SHALL saturate at CAPACITY and ovf SHALL pulse in the pulse cycle.
REQ-026 If count + delta < 0, count SHALL saturate at 0 and unf SHALL pulse in the pulse cycle.
REQ-027 Simultaneous entry and exit on different lanes SHALL cancel (count unchanged, no ovf/unf even when full or empty).
REQ-028 Lane FSMs SHALL continue to count while full; full SHALL never block state transitions.
REQ-029 full/empty SHALL be derived from the registered count, not from next-state.

Reset
REQ-030 On rst high at a clock edge: all lane FSMs -> IDLE, count = 0, empty = 1, full = 0, filter state cleared to 0.
REQ-031 While rst is high incr, decr, ovf, unf SHALL be 0; a vehicle in transit at reset is discarded.
REQ-032 After rst deasserts, sensors already blocked SHALL not produce a pulse until a legal IDLE-starting sequence is seen.

Configuration
REQ-033 Macro PARKING_DEBOUNCE_EN: when defined, each sensor bit SHALL pass a 2-flop synchroniser then a filter updating its output only after DEBOUNCE_CYCLES identical consecutive samples.
REQ-034 With PARKING_DEBOUNCE_EN defined, sensor-to-FSM latency SHALL be 2 + DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES SHALL be ignored.
REQ-035 Without PARKING_DEBOUNCE_EN, raw sensors SHALL feed the FSMs directly (zero latency); DEBOUNCE_CYCLES unused.

Verification
REQ-036 Lane 0 sequence 00,10,11,01,00 (each held 8 cycles) -> one incr[0] pulse, count 0 -> 1, empty falls.
REQ-037 Lane 1 sequence 00,01,11,10,00 with count = 3 -> one decr[1] pulse, count 3 -> 2.
REQ-038 Lane 0 sequence 10,11,10,00 (reversal then abort) -> no pulse, count unchanged.
REQ-039 CAPACITY = 2, count = 2, entry completes on lane 0 -> incr[0] and ovf pulse, count stays 2, full stays 1; same cycle entry lane 0 and exit lane 1 -> count 2, no ovf.
REQ-040 rst asserted while lane 0 in IN_2 with count = 5 -> next cycle count 0, lane IDLE, no pulse when sensors then go 01,00.
REQ-041 With PARKING_DEBOUNCE_EN, DEBOUNCE_CYCLES = 4: 2-cycle glitch 10 on lane 0 -> no state change; full entry sequence -> incr[0] 6 cycles after final 00 applied.
